// File: rtl/traffic_phase_timer.sv
// Phase timer for the traffic light controller: counts each phase up to its latched
// duration, reports completion, and can walk through the phases on its own.
module traffic_phase_timer #(
    parameter int CNT_W      = 5,
    parameter int NUM_PHASES = 4,
    parameter int PH_W       = $clog2(NUM_PHASES)
) (
    input  logic                        clk,
    input  logic                        n_reset,
    input  logic                        start,
    input  logic [PH_W-1:0]             start_phase,
    input  logic                        hold,
    input  logic                        auto_cycle,
    input  logic [NUM_PHASES*CNT_W-1:0] durations,
    output logic                        count_done,
    output logic                        done_pulse,
    output logic                        busy,
    output logic [PH_W-1:0]             phase,
    output logic [CNT_W-1:0]            count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(NUM_PHASES - 1);
    localparam logic [PH_W:0]   NUM_PH_EXT = (PH_W + 1)'(NUM_PHASES);

    logic [1:0]       state;
    logic [CNT_W-1:0] term;
    logic [PH_W-1:0]  load_phase;
    logic [PH_W-1:0]  next_phase;
    logic [CNT_W-1:0] load_dur;
    logic [CNT_W-1:0] next_dur;

    // Out-of-range start phases fall back to phase 0; next_phase wraps after the last phase.
    always_comb begin
        load_phase = ({1'b0, start_phase} < NUM_PH_EXT) ? start_phase : '0;
        next_phase = (phase == LAST_PHASE) ? '0 : phase + PH_W'(1);
        load_dur   = durations[int'(load_phase) * CNT_W +: CNT_W];
        next_dur   = durations[int'(next_phase) * CNT_W +: CNT_W];
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= ST_IDLE;
            count      <= '0;
            phase      <= '0;
            term       <= '0;
            done_pulse <= 1'b0;
        end else if (start) begin
            state      <= ST_RUN;
            phase      <= load_phase;
            count      <= '0;
            term       <= load_dur;
            done_pulse <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            if (state == ST_RUN && !hold) begin
                if (count != term) begin
                    count <= count + CNT_W'(1);
                end else begin
                    done_pulse <= 1'b1;
                    // Auto-cycle reloads the counter and the next phase's duration in one edge.
                    if (auto_cycle) begin
                        phase <= next_phase;
                        count <= '0;
                        term  <= next_dur;
                    end else begin
                        state <= ST_DONE;
                    end
                end
            end
        end
    end

    assign busy       = (state == ST_RUN);
    assign count_done = (state == ST_DONE);

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Bench for traffic_phase_timer: directed scenarios on two configurations plus a
// randomized run checked against a behavioural model of the phase rules.
module tb_traffic_phase_timer;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        start;
    logic        hold;
    logic        auto_cycle;
    logic [1:0]  sp0;
    logic [2:0]  sp1;
    logic [19:0] dur0;
    logic [14:0] dur1;

    logic       cd0, dp0, busy0;
    logic [1:0] ph0;
    logic [4:0] cnt0;
    logic       cd1, dp1, busy1;
    logic [2:0] ph1;
    logic [2:0] cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    int m_mode [2];
    int m_cnt  [2];
    int m_ph   [2];
    int m_term [2];
    bit m_pulse[2];

    traffic_phase_timer #(.CNT_W(5), .NUM_PHASES(4)) dut0 (
        .clk(clk), .n_reset(n_reset), .start(start), .start_phase(sp0), .hold(hold),
        .auto_cycle(auto_cycle), .durations(dur0), .count_done(cd0), .done_pulse(dp0),
        .busy(busy0), .phase(ph0), .count(cnt0)
    );

    traffic_phase_timer #(.CNT_W(3), .NUM_PHASES(5)) dut1 (
        .clk(clk), .n_reset(n_reset), .start(start), .start_phase(sp1), .hold(hold),
        .auto_cycle(auto_cycle), .durations(dur1), .count_done(cd1), .done_pulse(dp1),
        .busy(busy1), .phase(ph1), .count(cnt1)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input int which, input int budget, output int edges);
        edges = -1;
        for (int c = 1; c <= budget; c++) begin
            tick();
            if ((which == 0 ? dp0 : dp1) == 1'b1) begin
                edges = c;
                break;
            end
        end
    endtask

    function automatic int dur_of(input int i, input int ph);
        return (i == 0) ? int'(dur0[ph*5 +: 5]) : int'(dur1[ph*3 +: 3]);
    endfunction

    // Reference: one clock edge of the phase timer's rules applied to the sampled inputs.
    task automatic model_step(input int i);
        int np;
        int sp;
        np = (i == 0) ? 4 : 5;
        sp = (i == 0) ? int'(sp0) : int'(sp1);
        m_pulse[i] = 1'b0;
        if (start) begin
            m_ph[i]   = (sp < np) ? sp : 0;
            m_cnt[i]  = 0;
            m_term[i] = dur_of(i, m_ph[i]);
            m_mode[i] = M_RUN;
        end else if (m_mode[i] == M_RUN && !hold) begin
            if (m_cnt[i] < m_term[i]) begin
                m_cnt[i] = m_cnt[i] + 1;
            end else begin
                m_pulse[i] = 1'b1;
                if (auto_cycle) begin
                    m_ph[i]   = (m_ph[i] + 1) % np;
                    m_cnt[i]  = 0;
                    m_term[i] = dur_of(i, m_ph[i]);
                end else begin
                    m_mode[i] = M_DONE;
                end
            end
        end
    endtask

    task automatic test_reset();
        n_reset = 1'b0; start = 1'b0; hold = 1'b0; auto_cycle = 1'b0;
        sp0 = '0; sp1 = '0; dur0 = '0; dur1 = '0;
        repeat (2) tick();
        n_checks++;
        if ({cnt0, ph0, busy0, cd0, dp0} !== 10'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_dut0: got %0h expected 0", {cnt0, ph0, busy0, cd0, dp0});
        end
        n_checks++;
        if ({cnt1, ph1, busy1, cd1, dp1} !== 9'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_dut1: got %0h expected 0", {cnt1, ph1, busy1, cd1, dp1});
        end
        n_reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({busy0, cd0, cnt0} !== 7'd0) begin
            n_fail++;
            $display("[TB] FAIL idle_after_reset: got %0h expected 0", {busy0, cd0, cnt0});
        end
    endtask

    task automatic test_single_phase();
        dur0 = $urandom;
        dur0[5 +: 5] = 5'd5;
        auto_cycle = 1'b0; sp0 = 2'd1; start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if ({busy0, cnt0, ph0} !== {1'b1, 5'd0, 2'd1}) begin
            n_fail++;
            $display("[TB] FAIL single_load: got %0h expected %0h", {busy0, cnt0, ph0}, {1'b1, 5'd0, 2'd1});
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_checks++;
            if ({cnt0, dp0, cd0} !== {5'(k), 2'b00}) begin
                n_fail++;
                $display("[TB] FAIL single_count k=%0d: got %0h expected %0h", k, {cnt0, dp0, cd0}, {5'(k), 2'b00});
            end
        end
        tick();
        n_checks++;
        if ({dp0, cd0, busy0, cnt0, ph0} !== {3'b110, 5'd5, 2'd1}) begin
            n_fail++;
            $display("[TB] FAIL single_terminal: got %0h expected %0h", {dp0, cd0, busy0, cnt0, ph0}, {3'b110, 5'd5, 2'd1});
        end
        tick();
        n_checks++;
        if ({dp0, cd0, cnt0} !== {2'b01, 5'd5}) begin
            n_fail++;
            $display("[TB] FAIL single_done_hold: got %0h expected %0h", {dp0, cd0, cnt0}, {2'b01, 5'd5});
        end
    endtask

    task automatic test_auto_cycle();
        int d[4] = '{3, 0, 2, 1};
        int exp_t = 0;
        int ph;
        int edge_n = 0;
        int got;
        bit cd_seen = 1'b0;
        for (int i = 0; i < 4; i++) dur0[i*5 +: 5] = 5'(d[i]);
        sp0 = 2'd2; auto_cycle = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int p = 0; p < 4; p++) begin
            ph = (2 + p) % 4;
            exp_t = exp_t + d[ph] + 1;
            got = -1;
            for (int c = 0; c < 20 && got < 0; c++) begin
                tick();
                edge_n++;
                if (cd0) cd_seen = 1'b1;
                if (dp0) got = edge_n;
            end
            n_checks++;
            if (got !== exp_t) begin
                n_fail++;
                $display("[TB] FAIL auto_pulse_time %0d: got %0d expected %0d", p, got, exp_t);
            end
            n_checks++;
            if ({ph0, cnt0} !== {2'((ph + 1) % 4), 5'd0}) begin
                n_fail++;
                $display("[TB] FAIL auto_phase %0d: got %0h expected %0h", p, {ph0, cnt0}, {2'((ph + 1) % 4), 5'd0});
            end
        end
        n_checks++;
        if (cd_seen !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL auto_count_done: got %0d expected 0", cd_seen);
        end
        auto_cycle = 1'b0;
    endtask

    task automatic test_hold();
        int got;
        dur0[0 +: 5] = 5'd7; sp0 = 2'd0; auto_cycle = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if ({cnt0, dp0} !== {5'd3, 1'b0}) begin
                n_fail++;
                $display("[TB] FAIL hold_frozen %0d: got %0h expected %0h", k, {cnt0, dp0}, {5'd3, 1'b0});
            end
        end
        hold = 1'b0;
        wait_pulse(0, 20, got);
        n_checks++;
        if (got + 7 !== 12) begin
            n_fail++;
            $display("[TB] FAIL hold_delay: got %0d expected %0d", got + 7, 12);
        end
        hold = 1'b1; auto_cycle = 1'b1;
        repeat (2) tick();
        n_checks++;
        if ({cd0, busy0, dp0, cnt0} !== {3'b100, 5'd7}) begin
            n_fail++;
            $display("[TB] FAIL done_ignores_hold: got %0h expected %0h", {cd0, busy0, dp0, cnt0}, {3'b100, 5'd7});
        end
        hold = 1'b0; auto_cycle = 1'b0;
    endtask

    task automatic test_restart();
        int got;
        dur0[0 +: 5] = 5'd2; sp0 = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if ({dp0, cd0, busy0, cnt0} !== {3'b001, 5'd0}) begin
            n_fail++;
            $display("[TB] FAIL restart_collision: got %0h expected %0h", {dp0, cd0, busy0, cnt0}, {3'b001, 5'd0});
        end
        wait_pulse(0, 10, got);
        n_checks++;
        if (got !== 3) begin
            n_fail++;
            $display("[TB] FAIL restart_rerun: got %0d expected 3", got);
        end
        repeat (2) tick();
        dur0[5 +: 5] = 5'd4; sp0 = 2'd1; start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if ({cd0, busy0, cnt0, ph0} !== {2'b01, 5'd0, 2'd1}) begin
            n_fail++;
            $display("[TB] FAIL restart_from_done: got %0h expected %0h", {cd0, busy0, cnt0, ph0}, {2'b01, 5'd0, 2'd1});
        end
        wait_pulse(0, 10, got);
        n_checks++;
        if (got !== 5) begin
            n_fail++;
            $display("[TB] FAIL restart_done_len: got %0d expected 5", got);
        end
        for (int v = 3; v <= 7; v++) begin
            sp1 = 3'(v); start = 1'b1;
            tick();
            start = 1'b0;
            n_checks++;
            if (ph1 !== ((v < 5) ? 3'(v) : 3'd0)) begin
                n_fail++;
                $display("[TB] FAIL phase_map sp=%0d: got %0d expected %0d", v, ph1, (v < 5) ? v : 0);
            end
        end
    endtask

    task automatic test_async_reset();
        int got;
        dur0[15 +: 5] = 5'd10; sp0 = 2'd3; auto_cycle = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({cnt0, ph0} !== {5'd3, 2'd3}) begin
            n_fail++;
            $display("[TB] FAIL async_precount: got %0h expected %0h", {cnt0, ph0}, {5'd3, 2'd3});
        end
        #2 n_reset = 1'b0;
        #1;
        n_checks++;
        if ({cnt0, ph0, busy0, cd0, dp0} !== 10'd0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got %0h expected 0", {cnt0, ph0, busy0, cd0, dp0});
        end
        #1 n_reset = 1'b1;
        repeat (2) tick();
        n_checks++;
        if ({busy0, cnt0} !== 6'd0) begin
            n_fail++;
            $display("[TB] FAIL async_stays_idle: got %0h expected 0", {busy0, cnt0});
        end
        dur0[0 +: 5] = 5'd4; sp0 = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        dur0[0 +: 5] = 5'd9;
        wait_pulse(0, 20, got);
        n_checks++;
        if (got + 2 !== 5) begin
            n_fail++;
            $display("[TB] FAIL latched_duration: got %0d expected 5", got + 2);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_pulse(0, 20, got);
        n_checks++;
        if (got !== 10) begin
            n_fail++;
            $display("[TB] FAIL new_duration_load: got %0d expected 10", got);
        end
    endtask

    task automatic test_wide_terminal();
        dur1[6 +: 3] = 3'd7; sp1 = 3'd2; auto_cycle = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 7; k++) begin
            if (k > 0) tick();
            n_checks++;
            if ({cnt1, dp1} !== {3'(k), 1'b0}) begin
                n_fail++;
                $display("[TB] FAIL wide_count k=%0d: got %0h expected %0h", k, {cnt1, dp1}, {3'(k), 1'b0});
            end
        end
        tick();
        n_checks++;
        if ({dp1, cd1, cnt1} !== {2'b11, 3'd7}) begin
            n_fail++;
            $display("[TB] FAIL wide_terminal: got %0h expected %0h", {dp1, cd1, cnt1}, {2'b11, 3'd7});
        end
    endtask

    task automatic test_random();
        logic [9:0] exp0;
        logic [8:0] exp1;
        start = 1'b0; hold = 1'b0; auto_cycle = 1'b0;
        n_reset = 1'b0;
        tick();
        n_reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_IDLE; m_cnt[i] = 0; m_ph[i] = 0; m_term[i] = 0; m_pulse[i] = 1'b0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            start = ($urandom_range(0, 9) == 0);
            hold  = ($urandom_range(0, 3) == 0);
            sp0   = 2'($urandom);
            sp1   = 3'($urandom);
            if ($urandom_range(0, 15) == 0) auto_cycle = 1'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                for (int p = 0; p < 4; p++)
                    dur0[p*5 +: 5] = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 6));
                for (int p = 0; p < 5; p++)
                    dur1[p*3 +: 3] = 3'($urandom_range(0, 7));
            end
            tick();
            model_step(0);
            model_step(1);
            exp0 = {5'(m_cnt[0]), 2'(m_ph[0]), m_mode[0] == M_RUN, m_mode[0] == M_DONE, m_pulse[0]};
            exp1 = {3'(m_cnt[1]), 3'(m_ph[1]), m_mode[1] == M_RUN, m_mode[1] == M_DONE, m_pulse[1]};
            n_checks++;
            if ({cnt0, ph0, busy0, cd0, dp0} !== exp0) begin
                n_fail++;
                $display("[TB] FAIL random_dut0 cyc=%0d: got %0h expected %0h", cyc, {cnt0, ph0, busy0, cd0, dp0}, exp0);
            end
            n_checks++;
            if ({cnt1, ph1, busy1, cd1, dp1} !== exp1) begin
                n_fail++;
                $display("[TB] FAIL random_dut1 cyc=%0d: got %0h expected %0h", cyc, {cnt1, ph1, busy1, cd1, dp1}, exp1);
            end
        end
        start = 1'b0; hold = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_phase();
        test_auto_cycle();
        test_hold();
        test_restart();
        test_async_reset();
        test_wide_terminal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
